// File: rtl/sobel_window_core.sv
// Streaming 3x3 Sobel stage: RGB column taps -> luma window -> saturated |Gx|+|Gy|.
// Three-stage pipeline (window shift, gradients, magnitude) with valid/coords riding alongside.
module sobel_window_core #(
  parameter int unsigned WIDTH      = 100,
  parameter int unsigned HEIGHT     = 100,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      row0,
  input  logic [DATA_WIDTH-1:0]      row1,
  input  logic [DATA_WIDTH-1:0]      row2,
  output logic                       out_valid,
  output logic [7:0]                 out_pixel,
  output logic [$clog2(WIDTH)-1:0]   out_x,
  output logic [$clog2(HEIGHT)-1:0]  out_y,
  output logic                       frame_done
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] XCtrLast = XW'(WIDTH - 2);
  localparam logic [YW-1:0] YCtrLast = YW'(HEIGHT - 2);

  function automatic logic [7:0] luma(input logic [DATA_WIDTH-1:0] px);
    logic [9:0] s;
    s = {2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]};
    return s[9:2];
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  // win_q[r][c]: r=0 is the top (oldest) row, c=0 the oldest column
  logic [7:0]    win_q [3][3];
  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;

  logic          s1_valid_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;

  logic                 s2_valid_q;
  logic [XW-1:0]        s2_x_q;
  logic [YW-1:0]        s2_y_q;
  logic signed [10:0]   gx_q, gy_q;

  logic [9:0]         gx_p, gx_n, gy_p, gy_n;
  logic signed [10:0] gx_d, gy_d;
  logic [11:0]        mag;

  // S1: counters, window shift and the valid/centre tag for the new window
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      s1_valid_q <= in_valid && (col_q >= XW'(2)) && (row_q >= YW'(2));
      if (in_valid) begin
        s1_x_q <= col_q - XW'(1);
        s1_y_q <= row_q - YW'(1);
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= luma(row2);
        win_q[1][2] <= luma(row1);
        win_q[2][2] <= luma(row0);
        if (col_q == XLast) begin
          col_q <= '0;
          row_q <= (row_q == YLast) ? '0 : row_q + YW'(1);
        end else begin
          col_q <= col_q + XW'(1);
        end
      end
    end
  end

  always_comb begin
    gx_p = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
    gx_n = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    gy_p = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
    gy_n = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
    gx_d = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
    gy_d = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
  end

  // S2: gradient registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_x_q <= s1_x_q;
        s2_y_q <= s1_y_q;
        gx_q   <= gx_d;
        gy_q   <= gy_d;
      end
    end
  end

  always_comb begin
    mag = {1'b0, abs11(gx_q)} + {1'b0, abs11(gy_q)};
  end

  // S3: magnitude, saturation and output registers; data holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s2_valid_q;
      frame_done <= s2_valid_q && (s2_x_q == XCtrLast) && (s2_y_q == YCtrLast);
      if (s2_valid_q) begin
        out_pixel <= (mag > 12'd255) ? 8'hFF : mag[7:0];
        out_x     <= s2_x_q;
        out_y     <= s2_y_q;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_core.sv
// Bench for sobel_window_core: image-level Sobel model with a per-cycle scoreboard,
// plus literal checks for flat, step, luma, ramp, gapped, reset and back-to-back frames.
module tb_sobel_window_core;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] row0 = '0, row1 = '0, row2 = '0;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        frame_done;

  sobel_window_core #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .row0       (row0),
    .row1       (row1),
    .row2       (row2),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int pix; int x; int y; int fd; } exp_t;
  typedef struct { int pix; int x; int y; int fd; int cyc; } cap_t;

  exp_t        exp_q[$];
  cap_t        cap[$];
  cap_t        ref_seq[$];
  logic [23:0] pic [H][W];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          acc22 = 0;
  int          hold_pix = 0, hold_x = 0, hold_y = 0;
  logic        rst_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  function automatic int lum(input logic [23:0] p);
    return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
  endfunction

  // Sobel magnitude for the window whose bottom-right pixel is (x,y)
  function automatic int sobel_at(input int x, input int y);
    int gx = 0, gy = 0, v, m;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v  = lum(pic[y - 2 + r][x - 2 + c]);
        gx += (c - 1) * ((r == 1) ? 2 : 1) * v;
        gy += (r - 1) * ((c == 1) ? 2 : 1) * v;
      end
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [23:0] make_pix(input int pat, input int x, input int y);
    logic [7:0] g;
    case (pat)
      0:       return 24'h808080;
      1:       return (x < 4) ? 24'h000000 : 24'hFFFFFF;
      2:       return (x < 4) ? 24'h000000 : 24'h104020;
      3: begin g = 8'(10 * x); return {g, g, g}; end
      default: return 24'($urandom);
    endcase
  endfunction

  // Scoreboard: every cycle, either the due word appears or the outputs stay quiet and held
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      hold_pix = 0; hold_x = 0; hold_y = 0;
    end
    rst_prev = rst;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      if (!out_valid || int'(out_pixel) != e.pix || int'(out_x) != e.x || int'(out_y) != e.y ||
          int'(frame_done) != e.fd) begin
        n_fail++;
        $display("FAIL out_word @cyc %0d: got v=%0d pix=%0d (%0d,%0d) fd=%0d, expected v=1 pix=%0d (%0d,%0d) fd=%0d",
                 cyc, out_valid, out_pixel, out_x, out_y, frame_done, e.pix, e.x, e.y, e.fd);
      end
    end else begin
      n_tests++;
      if (out_valid || frame_done || int'(out_pixel) != hold_pix || int'(out_x) != hold_x ||
          int'(out_y) != hold_y) begin
        n_fail++;
        $display("FAIL idle_hold @cyc %0d: got v=%0d fd=%0d pix=%0d (%0d,%0d), expected v=0 fd=0 pix=%0d (%0d,%0d)",
                 cyc, out_valid, frame_done, out_pixel, out_x, out_y, hold_pix, hold_x, hold_y);
      end
    end
    if (out_valid) begin
      cap.push_back('{pix: int'(out_pixel), x: int'(out_x), y: int'(out_y),
                      fd: int'(frame_done), cyc: cyc});
      hold_pix = int'(out_pixel); hold_x = int'(out_x); hold_y = int'(out_y);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Streams one frame; stop_at >= 0 ends it early after that many accepts
  task automatic run_frame(input int pat, input int gap_pct, input int stop_at);
    int idx = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pic[y][x] = make_pix(pat, x, y);
      end
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (stop_at >= 0 && idx == stop_at) return;
        while (int'($urandom_range(0, 99)) < gap_pct) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          row0 = 24'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        row0 = pic[y][x];
        row1 = (y >= 1) ? pic[y - 1][x] : 24'h0;
        row2 = (y >= 2) ? pic[y - 2][x] : 24'h0;
        if (x >= 2 && y >= 2) begin
          exp_q.push_back('{due: cyc + 3, pix: sobel_at(x, y), x: x - 1, y: y - 1,
                            fd: int'(x == W - 1 && y == H - 1)});
        end
        if (x == 2 && y == 2) acc22 = cyc + 1;
        idx++;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    row0 = 24'($urandom);
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pixel", int'(out_pixel), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_fd", int'(frame_done), 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_fd", int'(frame_done), 0);
  endtask

  initial begin
    int nfd;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_pixel", int'(out_pixel), 0);
    chk("reset_out_x", int'(out_x), 0);
    chk("reset_out_y", int'(out_y), 0);
    chk("reset_frame_done", int'(frame_done), 0);

    // Flat frame
    cap.delete();
    run_frame(0, 0, -1);
    idle(6);
    chk("flat_count", cap.size(), 24);
    for (int i = 0; i < cap.size(); i++) begin
      chk("flat_pix", cap[i].pix, 0);
      chk("flat_raster", cap[i].y * 8 + cap[i].x, ((i / 6) + 1) * 8 + (i % 6) + 1);
      chk("flat_fd", cap[i].fd, int'(i == 23));
    end
    if (cap.size() > 0) chk("flat_latency", cap[0].cyc - acc22, 2);

    // Vertical step
    cap.delete();
    run_frame(1, 0, -1);
    idle(6);
    chk("step_count", cap.size(), 24);
    for (int i = 0; i < cap.size(); i++) begin
      chk("step_pix", cap[i].pix, (cap[i].x == 3 || cap[i].x == 4) ? 255 : 0);
    end

    // Luma of 0x104020 is 44, so a black->0x104020 step gives 4*44 = 176
    cap.delete();
    run_frame(2, 0, -1);
    idle(6);
    if (cap.size() > 2) begin
      chk("luma_step_x3", cap[2].pix, 176);
      chk("luma_step_x4", cap[3].pix, 176);
      chk("luma_flat_x1", cap[0].pix, 0);
    end else begin
      chk("luma_count", cap.size(), 24);
    end

    // Grey ramp, continuous then gapped
    cap.delete();
    run_frame(3, 0, -1);
    idle(6);
    chk("ramp_count", cap.size(), 24);
    for (int i = 0; i < cap.size(); i++) chk("ramp_pix", cap[i].pix, 80);
    ref_seq = cap;
    cap.delete();
    run_frame(3, 50, -1);
    idle(6);
    chk("gap_count", cap.size(), ref_seq.size());
    for (int i = 0; i < cap.size() && i < ref_seq.size(); i++) begin
      chk("gap_seq", (cap[i].pix << 16) | (cap[i].x << 8) | cap[i].y,
          (ref_seq[i].pix << 16) | (ref_seq[i].x << 8) | ref_seq[i].y);
    end

    // Reset mid-row 3, then a fresh frame must start at (1,1)
    run_frame(4, 0, 3 * W + 4);
    pulse_reset();
    cap.delete();
    run_frame(4, 20, -1);
    idle(6);
    chk("after_rst_count", cap.size(), 24);
    if (cap.size() > 0) begin
      chk("after_rst_x", cap[0].x, 1);
      chk("after_rst_y", cap[0].y, 1);
    end

    // Back-to-back frames
    cap.delete();
    run_frame(4, 0, -1);
    run_frame(4, 0, -1);
    idle(6);
    chk("b2b_count", cap.size(), 48);
    nfd = 0;
    foreach (cap[i]) nfd += cap[i].fd;
    chk("b2b_fd_count", nfd, 2);
    if (cap.size() == 48) begin
      chk("b2b_f2_x", cap[24].x, 1);
      chk("b2b_f2_y", cap[24].y, 1);
      chk("b2b_f1_last_fd", cap[23].fd, 1);
    end

    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_core.md
# sobel_window_core

Streaming 3x3 Sobel stage directly downstream of the three-row line buffer. Each accepted pixel brings one 24-bit RGB column (three vertically aligned taps). The block converts the taps to 8-bit luma, keeps a 3x3 window, and computes |Gx|+|Gy|. It emits one saturated 8-bit edge magnitude per interior pixel, with coordinates and an end-of-frame pulse.

## Interface
- WIDTH, 100, pixels per row; must match the line buffer's WIDTH; minimum 3
- HEIGHT, 100, rows per frame; minimum 3
- DATA_WIDTH, 24, tap width in RGB888; R=[23:16], G=[15:8], B=[7:0]
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  column accepted this edge; driven by the same strobe as the line buffer's shift_en
- row0  input  DATA_WIDTH  bottom tap (newest row)
- row1  input  DATA_WIDTH  middle tap
- row2  input  DATA_WIDTH  top tap (oldest row)
- out_valid  output  1  out_pixel/out_x/out_y valid this cycle
- out_pixel  output  8  edge magnitude, saturated to 255
- out_x  output  $clog2(WIDTH)  window-centre column
- out_y  output  $clog2(HEIGHT)  window-centre row
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame

## Operation
- Luma per tap: Y = (R + 2G + B) >> 2. Use a 10-bit intermediate, truncate to 8 bits, no rounding.
- Window w[r][c], where r=0 is the top row (row2) and c=0 is the oldest column.
- On in_valid, columns shift: c0<=c1, c1<=c2, c2<=new luma column.
- Input counters col_in (0..WIDTH-1) and row_in (0..HEIGHT-1) advance on in_valid.
  - col_in wraps to 0 and row_in increments.
  - After (WIDTH-1, HEIGHT-1), both wrap to 0 for the next frame.
- A window is valid when the accepted pixel has col_in>=2 and row_in>=2.
  - Centre is (col_in-1, row_in-1), so only interior pixels are emitted: (WIDTH-2)*(HEIGHT-2) outputs per frame.
  - Stale columns from the previous row are excluded by the col_in>=2 rule; no window flush is needed.
- Gx = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
- Gy = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
- Gx and Gy are 11-bit signed, range ±1020.
- Magnitude = |Gx| + |Gy|, 12-bit unsigned, max 2040; values >255 saturate to 255.
- Pipeline:
  - S1: luma conversion and window shift, on the accept edge.
  - S2: Gx/Gy registers.
  - S3: magnitude, saturation, output registers.
- A valid bit plus coordinates travel alongside the data. The pipeline advances every cycle and has no stall. in_valid gaps only create out_valid gaps.
- frame_done asserts when the S3 word carries centre (WIDTH-2, HEIGHT-2).

## Timing
- Reset: all outputs 0, both counters 0, window 0, all pipeline valid bits 0.
- Reset mid-frame: in-flight results are discarded, and no out_valid or frame_done appears in the cycle after rst is released. The next in_valid is treated as pixel (0,0).
- Latency: a pixel accepted at edge N appears at edge N+2 (out_valid high for one cycle after that edge).
- Throughput: one output per cycle under continuous in_valid.
- out_valid is high for exactly one cycle per emitted pixel. out_pixel/out_x/out_y hold their last values while out_valid=0.
- Row-boundary rule: the first two accepts of each row produce no output.
- Frame-boundary rule: frame_done for frame k and the first accept of frame k+1 may coincide with no interaction.
- in_valid is ignored while rst=1.

## Test plan
- Reset: stream a WIDTH=8, HEIGHT=6 frame and assert rst for 2 cycles mid-row 3 -> out_valid, frame_done and out_pixel are 0 during and after reset; the next frame starts at out_x=1, out_y=1.
- Flat frame: all taps 0x808080, WIDTH=8, HEIGHT=6, continuous in_valid -> exactly 24 outputs, all 0, in raster order (1,1)..(6,4); frame_done only with (6,4); first out_valid 2 edges after accept of (2,2).
- Vertical step: columns 0..3 = 0x000000, columns 4..7 = 0xFFFFFF -> out_pixel 255 at x=3 and x=4 on every row, 0 elsewhere.
- Luma and ramp:
  - Single pixel 0x104020 gives luma 44.
  - Grey ramp with value 10·x per column -> Gx=80, Gy=0, out_pixel 80 at every interior position.
- Gapped input: the same ramp with in_valid randomly low 50% of cycles -> identical out_pixel/out_x/out_y sequence; each output appears 2 edges after its accepting edge.
- Back-to-back frames: two consecutive 8x6 frames -> exactly two frame_done pulses, 48 outputs, and out_y returns to 1 at the start of frame 2.
